// File: rtl/thr_fetch_ctrl.sv
// thr_fetch_ctrl: streams a run of threshold words out of a synchronous
// 1-cycle-latency ROM into a 4-entry FIFO and presents them on a
// valid/ready stream with a last flag.
//
// Handshake: a word transfers on a rising edge where thr_valid && thr_ready.
// thr_valid never depends on thr_ready. While thr_valid=1 and thr_ready=0,
// thr_data and thr_last hold stable.
module thr_fetch_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  thr_valid,
  input  logic                  thr_ready,
  output logic [DATA_WIDTH-1:0] thr_data,
  output logic                  thr_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] issue_left;
  logic [ADDR_WIDTH-1:0] out_left;
  logic                  rd_pend;

  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic [2:0]            occ;

  logic                  accept;
  logic                  go;
  logic                  zero_run;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic [2:0]            fill;

  // A start is taken only in IDLE and not on the cycle done is high.
  assign accept   = (state == S_IDLE) && start && !done;
  assign go       = accept && (count != '0);
  assign zero_run = accept && (count == '0);

  // Credit: buffered words plus the read still in the ROM pipe must stay
  // below the FIFO depth, so the FIFO can never overflow.
  assign fill     = occ + {2'b00, rd_pend};
  assign rom_en   = (state == S_FETCH) && (fill < 3'd4);
  assign rom_addr = rd_ptr;

  assign push      = rd_pend;
  assign thr_valid = (occ != 3'd0);
  assign pop       = thr_valid && thr_ready;
  assign thr_data  = fifo_mem[rd_idx];
  assign thr_last  = thr_valid && (out_left == ADDR_WIDTH'(1));
  assign last_pop  = pop && (out_left == ADDR_WIDTH'(1));

  assign busy = (state != S_IDLE);

  // Sequencer state, read pointer, run counters and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      issue_left <= '0;
      out_left   <= '0;
      done       <= 1'b0;
    end else begin
      done <= zero_run || ((state == S_DRAIN) && last_pop);
      if (pop) begin
        out_left <= out_left - ADDR_WIDTH'(1);
      end
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_FETCH;
            rd_ptr     <= base_addr;
            issue_left <= count;
            out_left   <= count;
          end
        end
        S_FETCH: begin
          if (rom_en) begin
            rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
            issue_left <= issue_left - ADDR_WIDTH'(1);
            if (issue_left == ADDR_WIDTH'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // rd_pend marks that rom_data carries a word this cycle; cleared by reset
  // so a read in flight at reset is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rom_en;
    end
  end

  // Output FIFO storage and pointers; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_idx] <= rom_data;
        wr_idx           <= wr_idx + 2'd1;
      end
      if (pop) begin
        rd_idx <= rd_idx + 2'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_thr_fetch_ctrl.sv
// tb_thr_fetch_ctrl: directed runs of thr_fetch_ctrl against a ROM model
// holding 0x1000+addr; stream words are scored against an expected queue.
module tb_thr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        thr_valid;
  logic        thr_ready;
  logic [31:0] thr_data;
  logic        thr_last;

  logic [31:0] rom_mem [256];
  logic [31:0] exp_q [$];
  int          n_vec;
  int          n_err;

  thr_fetch_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .thr_valid (thr_valid),
    .thr_ready (thr_ready),
    .thr_data  (thr_data),
    .thr_last  (thr_last)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered output, 1-cycle latency, not reset
  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = 32'h1000 + 32'(a);
  end
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one run. mode 0 = ready held 1, 1 = ready 0 for first 10
  // cycles, 2 = random ready. inj pulses ignored starts mid-run and on done.
  task automatic run(input logic [7:0] base, input logic [7:0] cnt,
                     input int mode, input bit inj);
    int          en_cnt;
    int          first_v;
    int          done_cyc;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] e;
    logic [7:0]  a;
    exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 8'(i);
      exp_q.push_back(32'h1000 + {24'h0, a});
    end
    en_cnt = 0; first_v = -1; done_cyc = -1; stalled = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; count = cnt; thr_ready = (mode == 0);
    for (int c = 1; c < 1500; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inj && c == 4) begin
        start = 1'b1; base_addr = 8'h40; count = 8'd5;
      end
      case (mode)
        0:       thr_ready = 1'b1;
        1:       thr_ready = (c > 10);
        default: thr_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == 1) begin
        check("busy_c1", {31'b0, busy}, {31'b0, cnt != 8'd0});
        check("rom_en_c1", {31'b0, rom_en}, {31'b0, cnt != 8'd0});
        if (cnt != 8'd0) check("rom_addr_c1", {24'b0, rom_addr}, {24'b0, base});
      end
      if (rom_en) en_cnt++;
      if (mode == 1 && c == 10) begin
        check("bp_en_cnt", 32'(en_cnt), 32'd4);
        check("bp_rom_en_off", {31'b0, rom_en}, 32'd0);
      end
      if (thr_valid && first_v < 0) first_v = c;
      if (stalled) begin
        check("stall_valid", {31'b0, thr_valid}, 32'd1);
        check("stall_data", thr_data, held);
      end
      if (thr_valid && thr_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", thr_data, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          check("data", thr_data, e);
          check("last", {31'b0, thr_last}, {31'b0, exp_q.size() == 0});
        end
      end
      stalled = thr_valid && !thr_ready;
      held    = thr_data;
      if (done) begin
        done_cyc = c;
        if (inj) begin
          start = 1'b1; base_addr = 8'h40; count = 8'd3;
        end
        break;
      end
    end
    check("done_seen", {31'b0, done_cyc > 0}, 32'd1);
    check("words_left", 32'(exp_q.size()), 32'd0);
    check("rom_en_count", 32'(en_cnt), {24'b0, cnt});
    if (mode == 0 && cnt != 8'd0) begin
      check("first_valid_cyc", 32'(first_v), 32'd3);
      check("done_cyc", 32'(done_cyc), 32'(cnt) + 32'd3);
    end
    if (cnt == 8'd0) check("zero_done_cyc", 32'(done_cyc), 32'd1);
    if (inj) begin
      @(negedge clk);
      start = 1'b0;
      check("done_start_busy", {31'b0, busy}, 32'd0);
      check("done_start_rom_en", {31'b0, rom_en}, 32'd0);
      check("done_start_done", {31'b0, done}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_rom_en"}, {31'b0, rom_en}, 32'd0);
    check({tag, "_rom_addr"}, {24'b0, rom_addr}, 32'd0);
    check({tag, "_valid"}, {31'b0, thr_valid}, 32'd0);
    check({tag, "_data"}, thr_data, 32'd0);
    check({tag, "_last"}, {31'b0, thr_last}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; thr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(8'h10, 8'd5, 0, 1'b0);     // basic
    run(8'h20, 8'd5, 0, 1'b0);     // start the cycle after done
    run(8'h30, 8'd8, 1, 1'b0);     // backpressure
    run(8'h05, 8'd255, 2, 1'b0);   // random ready, long run
    run(8'hFE, 8'd3, 0, 1'b0);     // address wrap
    run(8'h00, 8'd0, 0, 1'b0);     // zero count
    run(8'h60, 8'd6, 0, 1'b1);     // ignored starts

    // Reset mid-run with 3 words buffered
    @(negedge clk);
    start = 1'b1; base_addr = 8'h50; count = 8'd8; thr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_valid", {31'b0, thr_valid}, 32'd1);
    check("pre_reset_head", thr_data, 32'h1050);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    thr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_valid", {31'b0, thr_valid}, 32'd0);
    check("post_reset_busy", {31'b0, busy}, 32'd0);

    run(8'h10, 8'd5, 0, 1'b0);     // run after reset matches basic run

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
